sm83_dbg_uart: RTL
==================

Name: sm83_dbg_uart

Overview:
- Host-side endpoint of the CPU debug byte channel: a UART bridge that turns serial frames from the debug host into the toggle-handshake command stream consumed by the CPU debug interface.
- Also serializes that interface's response bytes back onto the UART TX line.
- Sits between the board UART pins and the debug interface inside the CPU.
- It is the other end of the data_rx_*/data_tx_* seq/ack protocol: here data_rx_* are driven and data_tx_* are consumed.

Parameters:
CLK_DIV, 104, clk cycles per UART bit (8N1); legal range 4..65535.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
uart_rx  in  1  serial line from host, asynchronous, idle high
uart_tx  out  1  serial line to host, idle high
data_rx  out  8  received command byte; stable while data_rx_seq != data_rx_ack
data_rx_valid  out  1  1 = stop bit was high; 0 = framing error (consumer acks and discards)
data_rx_seq  out  1  toggles once per new byte presented
data_rx_ack  in  1  consumer sets equal to data_rx_seq when the byte is consumed
data_tx  in  8  response byte from consumer
data_tx_seq  in  1  consumer toggles when data_tx holds a new byte
data_tx_ack  out  1  set equal to data_tx_seq when the byte has been fully transmitted
rx_overrun  out  1  sticky: a received byte was dropped because the previous one was unacked

Behaviour:
- Reset values:
  - uart_tx=1, data_rx_seq=0, data_tx_ack=0, data_rx=0, data_rx_valid=0, rx_overrun=0.
  - RX FSM and TX FSM go to IDLE; counters are cleared; the uart_rx synchronizer is preset to 1.
- Reset mid-frame abandons the frame with no handshake toggle.
- When reset is shared with the debug interface, it must be held >=2 cycles so both sides converge to seq==ack==0.
- RX input: 2-flop synchronizer on uart_rx; all RX logic uses the synchronized value.
- RX FSM:
  - IDLE: on synchronized low, go to START and load the counter with CLK_DIV/2 (integer division).
  - START: when the counter expires, re-sample. If high (glitch), return to IDLE with no effect. If low, go to DATA with bit index 0 and counter CLK_DIV.
  - DATA: sample once every CLK_DIV cycles at mid-bit; shift in LSB first; after the 8th bit go to STOP.
  - STOP: sample after CLK_DIV cycles, then perform handoff.
    - Stop bit 1: return to IDLE immediately, which permits back-to-back frames.
    - Stop bit 0 (framing error or break): go to WAITHI, which returns to IDLE only after the synchronized line is seen high.
- RX handoff, in the cycle after the stop sample:
  - If data_rx_seq == data_rx_ack: data_rx <= byte, data_rx_valid <= stop bit, data_rx_seq <= ~data_rx_seq.
  - Otherwise: drop the byte, leave data_rx/data_rx_valid/data_rx_seq unchanged, and set rx_overrun <= 1. Only reset clears rx_overrun.
- TX FSM:
  - IDLE: when data_tx_seq != data_tx_ack, latch data_tx and the current data_tx_seq value into internal registers, drive uart_tx=0 on the next edge, and go to START.
  - data_tx is sampled only in that cycle; later changes are ignored.
  - START: 0 for CLK_DIV cycles.
  - DATA: 8 bits LSB first, CLK_DIV cycles each.
  - STOP: 1 for CLK_DIV cycles. At the final edge of STOP, data_tx_ack <= latched seq value and the FSM returns to IDLE.
- TX timing:
  - Mismatch seen at edge N: uart_tx falls at N+1.
  - data_tx_ack toggles at N+1+10*CLK_DIV.
  - With a continuous request, the next start bit follows at the earliest one IDLE cycle after the ack toggles.
- uart_tx is registered; it never glitches and is constant 1 in IDLE.
- RX and TX are independent: full duplex with simultaneous activity.
- A TX request arriving while RX is busy, or the reverse, has no interaction.
- Counter width is sized for CLK_DIV; the counter must not wrap within a bit period.

Test Plan:
- CLK_DIV=8, host sends 0x02 with correct framing -> within 10*8+4 cycles of the start edge, data_rx=0x02, data_rx_valid=1, data_rx_seq goes 0->1. Bench sets ack=1 -> no further toggle.
- data_tx=0xA5 with data_tx_seq 0->1 -> uart_tx bits 0,1,0,1,0,0,1,0,1,1, each exactly 8 cycles; data_tx_ack 0->1 exactly 81 cycles after the seq toggle is sampled. A change to data_tx during the frame does not alter the bits sent.
- Host sends 0x55 with stop bit 0, then line low for 40 cycles, then high -> data_rx=0x55, data_rx_valid=0, seq toggles once. No second byte is received until after the line returns high.
- Two frames 0x11, 0x22 back-to-back, ack withheld -> data_rx stays 0x11, seq toggles once, rx_overrun=1. After ack, a third frame 0x33 is delivered normally and rx_overrun stays 1.
- uart_rx pulled low for 3 cycles only (CLK_DIV=8) -> no toggle, RX back in IDLE; a following valid frame 0x7E is received correctly.
- Reset asserted mid-TX-frame for 2 cycles -> uart_tx=1 and data_tx_ack=0 from the next edge. With data_tx_seq=0, nothing is transmitted afterwards; with data_tx_seq=1, a fresh full frame starts.

Source files
------------

// File: rtl/sm83_dbg_uart_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : sm83_dbg_uart_if
// Brief    : seq/ack toggle-handshake byte channel between the UART bridge
//            (master) and the CPU debug interface (slave).
// Revision : 1.0
// ----------------------------------------------------------------------------
interface sm83_dbg_uart_if;
    logic [7:0] data_rx;
    logic       data_rx_valid;
    logic       data_rx_seq;
    logic       data_rx_ack;
    logic [7:0] data_tx;
    logic       data_tx_seq;
    logic       data_tx_ack;

    modport master (
        output data_rx, data_rx_valid, data_rx_seq, data_tx_ack,
        input  data_rx_ack, data_tx, data_tx_seq
    );

    modport slave (
        input  data_rx, data_rx_valid, data_rx_seq, data_tx_ack,
        output data_rx_ack, data_tx, data_tx_seq
    );
endinterface
`default_nettype wire

// File: rtl/sm83_dbg_uart.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : sm83_dbg_uart
// Brief    : 8N1 UART bridge to the CPU debug seq/ack byte channel.
// Revision : 1.0
// ----------------------------------------------------------------------------
module sm83_dbg_uart #(
    parameter int CLK_DIV = 104
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            uart_rx,
    output logic            uart_tx,
    output logic            rx_overrun,
    sm83_dbg_uart_if.master dbg
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] c_BIT      = CW'(CLK_DIV);
    localparam logic [CW-1:0] c_BIT_M1   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] c_HALF_M1  = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_STOP   = 3'd3,
        RX_WAITHI = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    logic            rx_meta_q, rx_sync_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_idx_q, rx_idx_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_done_q, rx_done_d;
    logic            rx_stop_q, rx_stop_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_seq_q, rx_seq_d;
    logic            rx_ovr_q, rx_ovr_d;

    tx_state_t       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_idx_q, tx_idx_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_seq_q, tx_seq_d;
    logic            tx_ack_q, tx_ack_d;
    logic            tx_line_q, tx_line_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_done_q  <= 1'b0;
            rx_stop_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_seq_q   <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_seq_q   <= 1'b0;
            tx_ack_q   <= 1'b0;
            tx_line_q  <= 1'b1;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_done_q  <= rx_done_d;
            rx_stop_q  <= rx_stop_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_seq_q   <= rx_seq_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_seq_q   <= tx_seq_d;
            tx_ack_q   <= tx_ack_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // Receiver: counters expire at zero, so a reload of N-1 spaces samples N cycles apart.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_done_d  = 1'b0;
        rx_stop_d  = rx_stop_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_seq_d   = rx_seq_q;
        rx_ovr_d   = rx_ovr_q;

        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = c_HALF_M1;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = c_BIT_M1;
                        rx_idx_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = c_BIT_M1;
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_done_d  = 1'b1;
                    rx_stop_d  = rx_sync_q;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_WAITHI;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_WAITHI: begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        // Handoff runs one cycle after the stop sample, independent of the FSM.
        if (rx_done_q) begin
            if (rx_seq_q == dbg.data_rx_ack) begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = rx_stop_q;
                rx_seq_d   = ~rx_seq_q;
            end else begin
                rx_ovr_d = 1'b1;
            end
        end
    end

    // Transmitter: the line register follows the current state one edge late;
    // STOP holds one extra cycle so the ack lands exactly as the stop bit ends.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_seq_d   = tx_seq_q;
        tx_ack_d   = tx_ack_q;
        tx_line_d  = 1'b1;

        case (tx_state_q)
            TX_IDLE: begin
                if (dbg.data_tx_seq != tx_ack_q) begin
                    tx_shift_d = dbg.data_tx;
                    tx_seq_d   = dbg.data_tx_seq;
                    tx_cnt_d   = c_BIT_M1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_line_d = 1'b0;
                if (tx_cnt_q == '0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = c_BIT_M1;
                    tx_idx_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            TX_DATA: begin
                tx_line_d = tx_shift_q[0];
                if (tx_cnt_q == '0) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_cnt_d   = c_BIT;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                        tx_cnt_d = c_BIT_M1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    tx_ack_d   = tx_seq_q;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign uart_tx           = tx_line_q;
    assign rx_overrun        = rx_ovr_q;
    assign dbg.data_rx       = rx_data_q;
    assign dbg.data_rx_valid = rx_valid_q;
    assign dbg.data_rx_seq   = rx_seq_q;
    assign dbg.data_tx_ack   = tx_ack_q;

endmodule
`default_nettype wire
